lp805x_sfrarb: RTL

//  Arbitrates the packed SFR request bus between NREQ requesters (port 0 = CPU core, others = debug/DMA).

---
 rtl/lp805x_sfrarb_pkg.sv | 60 ++++++
 rtl/lp805x_sfrarb_if.sv | 24 ++
 rtl/lp805x_sfrarb_pick.sv | 48 ++++
 rtl/lp805x_sfrarb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lp805x_sfrarb_pkg.sv
// Shared SFR bus definitions for the lp805x SFR arbiter: field positions,
// bus widths, arbiter state encodings and the request-to-bus encoder.
package lp805x_sfr_defs;

  localparam int SFR_BUS_W = 29;
  localparam int SFR_RSP_W = 9;
  localparam int MAXREQ    = 4;

  localparam int F_WR_ADDR = 21;
  localparam int F_RD_ADDR = 13;
  localparam int F_DATA_IN = 5;
  localparam int F_WR      = 4;
  localparam int F_RD      = 3;
  localparam int F_BIT_IN  = 2;
  localparam int F_WR_BIT  = 1;
  localparam int F_RD_BIT  = 0;

  localparam int RSP_DATA_LSB = 1;
  localparam int RSP_BIT      = 0;

  localparam logic [SFR_BUS_W-1:0] STROBE_MASK = 29'h0000_001B;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic       we;
    logic       bitacc;
    logic [7:0] addr;
    logic [7:0] wdata;
  } sfr_req_t;

  // Strobed bus word for one transfer; fields not used by the access stay 0.
  function automatic logic [SFR_BUS_W-1:0] sfr_encode(input sfr_req_t r);
    logic [SFR_BUS_W-1:0] b;
    b = '0;
    if (r.we) begin
      b[F_WR_ADDR +: 8] = r.addr;
      if (r.bitacc) begin
        b[F_BIT_IN] = r.wdata[0];
        b[F_WR_BIT] = 1'b1;
      end else begin
        b[F_DATA_IN +: 8] = r.wdata;
        b[F_WR]           = 1'b1;
      end
    end else begin
      b[F_RD_ADDR +: 8] = r.addr;
      if (r.bitacc) begin
        b[F_RD_BIT] = 1'b1;
      end else begin
        b[F_RD] = 1'b1;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/lp805x_sfrarb_if.sv
// Requester-side bundle of the SFR arbiter: requests in, ack and read data out.
interface lp805x_sfrarb_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]   m_req;
  logic [NREQ-1:0]   m_lock;
  logic [NREQ-1:0]   m_we;
  logic [NREQ-1:0]   m_bit;
  logic [8*NREQ-1:0] m_addr;
  logic [8*NREQ-1:0] m_wdata;
  logic [NREQ-1:0]   m_ack;
  logic [7:0]        m_rdata;
  logic              m_rbit;

  modport master (
    output m_req, m_lock, m_we, m_bit, m_addr, m_wdata,
    input  m_ack, m_rdata, m_rbit
  );

  modport slave (
    input  m_req, m_lock, m_we, m_bit, m_addr, m_wdata,
    output m_ack, m_rdata, m_rbit
  );

endinterface

// File: rtl/lp805x_sfrarb_pick.sv
// Combinational winner select: lock owner first, then round-robin from ptr
// or fixed lowest-index priority.
module lp805x_sfrarb_pick
  import lp805x_sfr_defs::*;
#(
  parameter int NREQ = 2,
  parameter bit RR   = 1'b1
) (
  input  logic [MAXREQ-1:0] req,
  input  logic              lock_vld,
  input  idx_t              lock_own,
  input  idx_t              ptr,
  output logic              any,
  output idx_t              win,
  output logic              by_lock
);

  int   idx_s;
  logic found_s;

  // Winner selection with lock override.
  always_comb begin
    any     = |req;
    win     = 2'd0;
    by_lock = 1'b0;
    idx_s   = 0;
    found_s = 1'b0;
    if (lock_vld && req[lock_own]) begin
      win     = lock_own;
      by_lock = 1'b1;
    end else if (RR) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = (int'(ptr) + k) % NREQ;
        if (!found_s && req[idx_t'(idx_s)]) begin
          win     = idx_t'(idx_s);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        win = req[idx_t'(k)] ? idx_t'(k) : win;
      end
    end
  end

endmodule

// File: rtl/lp805x_sfrarb.sv
// SFR bus arbiter: grants one requester, drives the strobed SFR request bus
// for one cycle and returns write completion or sampled read data with an ack.
module lp805x_sfrarb
  import lp805x_sfr_defs::*;
#(
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1,
  parameter bit RR     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lp805x_sfrarb_if.slave       req_if,
  output logic [SFR_BUS_W-1:0] sfr_bus,
  input  logic [SFR_RSP_W-1:0] rsp_bus,
  output logic                 busy
);

  logic [MAXREQ-1:0]   req_x, lock_x, we_x, bit_x;
  logic [8*MAXREQ-1:0] addr_x, wdata_x;
  sfr_req_t            sel_s;
  logic                any_s, by_lock_s;
  idx_t                win_s;

  logic [1:0]           state_q, state_d;
  idx_t                 gnt_q, gnt_d;
  idx_t                 ptr_q, ptr_d;
  logic                 we_q, we_d;
  logic                 lock_q, lock_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [SFR_BUS_W-1:0] bus_q, bus_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rbit_q, rbit_d;
  logic                 busy_q, busy_d;

  // Widen request fields to MAXREQ so a 2-bit grant index never runs off the end.
  always_comb begin
    req_x   = '0;
    lock_x  = '0;
    we_x    = '0;
    bit_x   = '0;
    addr_x  = '0;
    wdata_x = '0;
    req_x[NREQ-1:0]     = req_if.m_req;
    lock_x[NREQ-1:0]    = req_if.m_lock;
    we_x[NREQ-1:0]      = req_if.m_we;
    bit_x[NREQ-1:0]     = req_if.m_bit;
    addr_x[8*NREQ-1:0]  = req_if.m_addr;
    wdata_x[8*NREQ-1:0] = req_if.m_wdata;
    sel_s.we     = we_x[win_s];
    sel_s.bitacc = bit_x[win_s];
    sel_s.addr   = addr_x[{win_s, 3'b000} +: 8];
    sel_s.wdata  = wdata_x[{win_s, 3'b000} +: 8];
  end

  lp805x_sfrarb_pick #(
    .NREQ (NREQ),
    .RR   (RR)
  ) u_pick (
    .req      (req_x),
    .lock_vld (lock_q),
    .lock_own (gnt_q),
    .ptr      (ptr_q),
    .any      (any_s),
    .win      (win_s),
    .by_lock  (by_lock_s)
  );

  // Transfer sequencer: grant, strobe cycle, read latency wait, ack.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    rbit_d  = rbit_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          gnt_d   = win_s;
          we_d    = sel_s.we;
          lock_d  = lock_x[win_s];
          bus_d   = sfr_encode(sel_s);
          state_d = ST_ISSUE;
          if (by_lock_s) begin
            ptr_d = ptr_q;
          end else begin
            ptr_d = (win_s == idx_t'(NREQ - 1)) ? 2'd0 : win_s + 2'd1;
          end
        end else begin
          // An owner that skipped its re-request slot gives the lock up.
          lock_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        bus_d = bus_q & ~STROBE_MASK;
        if (we_q || (RD_LAT == 1)) begin
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
          state_d = ST_IDLE;
          if (!we_q) begin
            rdata_d = rsp_bus[RSP_DATA_LSB +: 8];
            rbit_d  = rsp_bus[RSP_BIT];
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d   = 3'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          rdata_d = rsp_bus[RSP_DATA_LSB +: 8];
          rbit_d  = rsp_bus[RSP_BIT];
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        bus_d   = bus_q & ~STROBE_MASK;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || lock_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'd0;
      ptr_q   <= 2'd0;
      we_q    <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= 3'd0;
      bus_q   <= '0;
      ack_q   <= '0;
      rdata_q <= 8'h00;
      rbit_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rbit_q  <= rbit_d;
      busy_q  <= busy_d;
    end
  end

  assign req_if.m_ack   = ack_q;
  assign req_if.m_rdata = rdata_q;
  assign req_if.m_rbit  = rbit_q;
  assign sfr_bus        = bus_q;
  assign busy           = busy_q;

endmodule
